// File: rtl/uart_tx_arbiter_if.sv
// Byte-request / serial-line bundle between the two requesters and the shared UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int DBIT = 8
);
  logic            req0;
  logic [DBIT-1:0] din0;
  logic            req1;
  logic [DBIT-1:0] din1;
  logic            ack0;
  logic            ack1;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            tx;

  modport master (
    output req0, din0, req1, din1,
    input  ack0, ack1, tx_busy, tx_done_tick, tx
  );

  modport slave (
    input  req0, din0, req1, din1,
    output ack0, ack1, tx_busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter plus 16x-oversampled UART serializer shared by two byte requesters.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_arbiter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  uart_tx_arbiter_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DBIT-1:0] d);
    return ^d;
  endfunction

  logic par_r;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t          state_r;
  logic [4:0]      s_r;
  logic [2:0]      n_r;
  logic [DBIT-1:0] b_r;
  logic            last_grant_r;
  logic            ack0_r;
  logic            ack1_r;
  logic            busy_r;
  logic            done_r;
  logic            tx_r;
  logic            grant0_s;
  logic            grant1_s;

  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.tx_busy      = busy_r;
  assign bus.tx_done_tick = done_r;
  assign bus.tx           = tx_r;

  // Grant selection: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (bus.req0 && (!bus.req1 || last_grant_r)) begin
      grant0_s = 1'b1;
    end else if (bus.req1) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Arbiter/serializer FSM; tx is loaded with the value of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      s_r          <= 5'd0;
      n_r          <= 3'd0;
      b_r          <= '0;
      last_grant_r <= 1'b1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tx_r         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant0_s) begin
            b_r          <= bus.din0;
            ack0_r       <= 1'b1;
            last_grant_r <= 1'b0;
            s_r          <= 5'd0;
            n_r          <= 3'd0;
            state_r      <= START;
            tx_r         <= 1'b0;
            busy_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r        <= even_parity(bus.din0);
`endif
          end else if (grant1_s) begin
            b_r          <= bus.din1;
            ack1_r       <= 1'b1;
            last_grant_r <= 1'b1;
            s_r          <= 5'd0;
            n_r          <= 3'd0;
            state_r      <= START;
            tx_r         <= 1'b0;
            busy_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r        <= even_parity(bus.din1);
`endif
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_r == 5'd15) begin
              s_r     <= 5'd0;
              state_r <= DATA;
              tx_r    <= b_r[0];
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_r == 5'd15) begin
              s_r <= 5'd0;
              b_r <= b_r >> 1;
              if (n_r == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                state_r <= PARITY;
                tx_r    <= par_r;
`else
                state_r <= STOP;
                tx_r    <= 1'b1;
`endif
              end else begin
                // b_r[1] becomes b_r[0] after this edge's shift
                n_r  <= n_r + 3'd1;
                tx_r <= b_r[1];
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_r == 5'd15) begin
              s_r     <= 5'd0;
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_r == 5'(SB_TICK - 1)) begin
              s_r     <= 5'd0;
              state_r <= IDLE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              tx_r    <= 1'b1;
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= 5'd0;
          busy_r  <= 1'b0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (SB_TICK 16 and 32) sharing clk, reset and s_tick.
module tb_uart_tx_arbiter;
  logic clk;
  logic reset;
  logic s_tick;
  int   tick_per;
  int   tcnt;
  bit   sel;
  int   npass;
  int   nfail;
  int   ntotal;

  uart_tx_arbiter_if #(.DBIT(8)) ifa ();
  uart_tx_arbiter_if #(.DBIT(8)) ifb ();

  uart_tx_arbiter #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .bus    (ifa.slave)
  );

  uart_tx_arbiter #(.DBIT(8), .SB_TICK(32)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .bus    (ifb.slave)
  );

  logic mon_tx, mon_busy, mon_done, mon_ack0, mon_ack1;
  assign mon_tx   = sel ? ifb.tx           : ifa.tx;
  assign mon_busy = sel ? ifb.tx_busy      : ifa.tx_busy;
  assign mon_done = sel ? ifb.tx_done_tick : ifa.tx_done_tick;
  assign mon_ack0 = sel ? ifb.ack0         : ifa.ack0;
  assign mon_ack1 = sel ? ifb.ack1         : ifa.ack1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud-tick source: one-clk pulse every tick_per clocks, constant high when tick_per is 1.
  initial begin
    s_tick = 1'b0;
    tcnt   = 0;
    forever begin
      @(negedge clk);
      if (tcnt >= tick_per - 1) begin
        tcnt   = 0;
        s_tick = 1'b1;
      end else begin
        tcnt   = tcnt + 1;
        s_tick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 0/1 for the acked requester, 2 if both acked, -1 on timeout; its = negedges waited.
  task automatic wait_grant(output int who, output int its);
    who = -1;
    its = 0;
    while (its < 2000) begin
      @(negedge clk);
      its++;
      if (mon_ack0 && mon_ack1) begin
        who = 2;
        break;
      end else if (mon_ack0) begin
        who = 0;
        break;
      end else if (mon_ack1) begin
        who = 1;
        break;
      end
    end
  endtask

  task automatic adv_ticks(input int n);
    int c;
    int it;
    c  = 0;
    it = 0;
    while (c < n && it < 20000) begin
      @(posedge clk);
      if (s_tick) c++;
      @(negedge clk);
      it++;
    end
    check("adv_ticks", c, n);
  endtask

  // Called at the negedge where ack is seen; follows the frame to the done pulse.
  task automatic run_frame(input logic [7:0] data, input int sb, input bit pulse);
    logic [10:0] bits;
    int nb, c, it, ndone, nack;
    bit inc;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^data;
    nb = 10;
`endif
    c = 0; it = 0; ndone = 0; nack = 0;
    while (c < nb * 16 + sb && it < 20000) begin
      @(posedge clk);
      inc = s_tick;
      if (inc) c++;
      @(negedge clk);
      it++;
      if (mon_done) ndone++;
      if (mon_ack0 || mon_ack1) nack++;
      if (pulse && it == 20) begin
        if (sel) ifb.req0 = 1'b1; else ifa.req0 = 1'b1;
      end
      if (pulse && it == 21) begin
        if (sel) ifb.req0 = 1'b0; else ifa.req0 = 1'b0;
      end
      if (inc && c < nb * 16 && (c % 16) == 8) check("frame_bit", {31'd0, mon_tx}, {31'd0, bits[c/16]});
      if (inc && c == nb * 16 + sb / 2) check("stop_mid", {31'd0, mon_tx}, 32'd1);
      if (inc && c == nb * 16 + sb - 1) begin
        check("stop_end_tx", {31'd0, mon_tx}, 32'd1);
        check("stop_end_busy", {31'd0, mon_busy}, 32'd1);
        check("no_early_done", ndone, 32'd0);
      end
    end
    check("frame_len", c, nb * 16 + sb);
    check("done_pulse", {31'd0, mon_done}, 32'd1);
    check("done_count", ndone, 32'd1);
    check("busy_after", {31'd0, mon_busy}, 32'd0);
    check("tx_idle", {31'd0, mon_tx}, 32'd1);
    check("ack_in_frame", nack, 32'd0);
  endtask

  initial begin
    int who, its, nack;
    npass = 0; nfail = 0; ntotal = 0;
    sel = 1'b0;
    tick_per = 54;
    reset = 1'b1;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.din0 = 8'h00; ifa.din1 = 8'h00;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.din0 = 8'h00; ifb.din1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, ifa.tx}, 32'd1);
    check("rst_busy", {31'd0, ifa.tx_busy}, 32'd0);
    check("rst_ack0", {31'd0, ifa.ack0}, 32'd0);
    check("rst_ack1", {31'd0, ifa.ack1}, 32'd0);
    check("rst_done", {31'd0, ifa.tx_done_tick}, 32'd0);
    check("rst_tx_b", {31'd0, ifb.tx}, 32'd1);
    reset = 1'b0;

    // Single request, 0x55 at 54 clk per tick
    @(negedge clk);
    ifa.din0 = 8'h55; ifa.req0 = 1'b1;
    wait_grant(who, its);
    check("single_grant", who, 32'd0);
    check("single_tx_start", {31'd0, mon_tx}, 32'd0);
    ifa.req0 = 1'b0;
    run_frame(8'h55, 16, 1'b0);
    @(negedge clk);
    check("single_done_1cyc", {31'd0, mon_done}, 32'd0);
    check("single_idle_busy", {31'd0, mon_busy}, 32'd0);

    // Simultaneous contention right after reset: req0 first
    tick_per = 2;
    reset = 1'b1;
    ifa.din0 = 8'hA3; ifa.din1 = 8'h3C; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_grant(who, its);
    check("cont_first", who, 32'd0);
    ifa.req0 = 1'b0;
    run_frame(8'hA3, 16, 1'b0);
    @(negedge clk);
    check("cont_second_ack1", {31'd0, mon_ack1}, 32'd1);
    check("cont_second_tx", {31'd0, mon_tx}, 32'd0);
    ifa.req1 = 1'b0;
    run_frame(8'h3C, 16, 1'b0);

    // Fairness with both held and s_tick constantly high
    tick_per = 1;
    ifa.din0 = 8'h96; ifa.din1 = 8'h41; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(who, its);
      check("fair_order", who, i % 2);
      if (i > 0) check("fair_gap", its, 32'd1);
      run_frame((i % 2 == 0) ? 8'h96 : 8'h41, 16, 1'b0);
      if (i == 3) begin
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
      end
    end
    @(negedge clk);
    check("fair_stop_busy", {31'd0, mon_busy}, 32'd0);

    // Reset during data bit 3 of 0xFF
    tick_per = 2;
    ifa.din0 = 8'hFF; ifa.req0 = 1'b1;
    wait_grant(who, its);
    check("rst_mid_grant", who, 32'd0);
    ifa.req0 = 1'b0;
    adv_ticks(16 * 4 + 8);
    check("rst_mid_busy_pre", {31'd0, mon_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, mon_tx}, 32'd1);
    check("rst_mid_busy", {31'd0, mon_busy}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_done", {31'd0, mon_done}, 32'd0);
    end
    reset = 1'b0;
    ifa.din1 = 8'h0F; ifa.req1 = 1'b1;
    wait_grant(who, its);
    check("post_rst_grant", who, 32'd1);
    ifa.req1 = 1'b0;
    run_frame(8'h0F, 16, 1'b0);

    // Two stop bits on the SB_TICK=32 instance; a 1-clk req0 pulse while busy is ignored
    sel = 1'b1;
    ifb.din0 = 8'h5A; ifb.req0 = 1'b1;
    wait_grant(who, its);
    check("sb32_grant", who, 32'd0);
    ifb.req0 = 1'b0;
    run_frame(8'h5A, 32, 1'b1);
    nack = 0;
    repeat (30) begin
      @(negedge clk);
      if (mon_ack0 || mon_ack1) nack++;
    end
    check("withdraw_no_ack", nack, 32'd0);
    check("withdraw_idle", {31'd0, mon_busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0
    sel = 1'b0;
    ifa.din0 = 8'h07; ifa.req0 = 1'b1;
    wait_grant(who, its);
    check("par07_grant", who, 32'd0);
    ifa.req0 = 1'b0;
    run_frame(8'h07, 16, 1'b0);
    ifa.din1 = 8'h03; ifa.req1 = 1'b1;
    wait_grant(who, its);
    check("par03_grant", who, 32'd1);
    ifa.req1 = 1'b0;
    run_frame(8'h03, 16, 1'b0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmitter between two byte requesters (e.g. ball-coordinate reporter and status/debug reporter) using round-robin arbitration.
- Sequences each start/data/stop frame from the 16x-oversampling enable tick produced by the baud divider (one tick = 1/16 bit time).
- Sits between the ball-locator packet logic and the board TX pin; contains arbiter and serializer FSM.

Parameters:
- DBIT, 8, data bits per frame, LSB first; legal 5..8.
- SB_TICK, 16, s_tick count for the stop bit; 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-high reset
- s_tick  input  1  one-clk-wide 16x baud enable from the baud divider
- req0  input  1  requester 0 byte request; level, held until ack0
- din0  input  DBIT  requester 0 byte; stable while req0 high
- req1  input  1  requester 1 byte request; level, held until ack1
- din1  input  DBIT  requester 1 byte; stable while req1 high
- ack0  output  1  one-cycle pulse: din0 latched, frame started
- ack1  output  1  one-cycle pulse: din1 latched, frame started
- tx_busy  output  1  high in any state other than IDLE
- tx_done_tick  output  1  one-cycle pulse at end of stop bit
- tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (async, any state): state=IDLE, tick counter s=0, bit counter n=0, shift reg b=0, last_grant=1, ack0=ack1=tx_busy=tx_done_tick=0, tx=1. A frame in progress is abandoned; no done pulse.
- States: IDLE, START, DATA, (PARITY, optional), STOP.
- IDLE: s_tick ignored. If only reqX high, grant X. If both high, grant the requester not equal to last_grant (req0 wins first after reset). On the grant edge: b<=dinX, ackX<=1 for exactly one cycle, last_grant<=X, s<=0, n<=0, state<=START.
- START: tx=0. On s_tick: s==15 -> s=0, state=DATA; else s++.
- DATA: tx=b[0]. On s_tick: s==15 -> s=0, b shifts right by 1, then n==DBIT-1 -> STOP (or PARITY), else n++; else s++.
- STOP: tx=1. On s_tick: s==SB_TICK-1 -> state=IDLE, tx_done_tick<=1 for one cycle; else s++.
- tx is registered from next-state logic: tx falls on the same edge ack rises; frame length = (1+DBIT)*16+SB_TICK ticks (+16 with parity).
- Back-to-back: state returns to IDLE on the done edge; the next grant occurs on the following edge if a request is pending (one idle clk between frames, tx stays 1).
- Requester dropping req before ack: request withdrawn, no frame. req/din changes while busy are ignored.
- s_tick held constantly high is legal (one tick per clk).
- s is 5 bits wide (covers SB_TICK up to 32); n is 3 bits.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA; tx = even parity (XOR of the DBIT latched bits, computed at grant) for 16 ticks; then STOP.
- Not defined: no PARITY state, DATA goes directly to STOP; no parity logic synthesized.

Test Plan:
- Single request: s_tick every 54 clk, req0=1, din0=8'h55 -> ack0 one cycle, tx bits 0,1,0,1,0,1,0,1,0,1 each 864 clk, stop high 864 clk, tx_done_tick once, tx_busy low afterwards.
- Simultaneous first contention: req0=req1=1 after reset, din0=8'hA3, din1=8'h3C -> ack0 first, frame 8'hA3; one idle clk; ack1, frame 8'h3C.
- Fairness: req0 and req1 held high continuously for 4 frames -> grant order 0,1,0,1; ack never overlaps; no frame corruption.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hFF -> tx=1 and tx_busy=0 immediately (async), no done pulse; subsequent req1 8'h0F sent correctly.
- Stop length and withdrawal: SB_TICK=32 -> stop bit 2x bit time; req0 pulsed 1 clk during busy frame -> no ack0, no extra frame.
- UART_TX_PARITY_EN defined: din0=8'h07 -> parity bit 1; din0=8'h03 -> parity bit 0; frame 11 bit times.
